// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one video RAM between the CRT fetch engine and the CPU.
// Fixed video priority with a CPU starvation guard; sequences setup/access/done.
module vram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_CPU_WAIT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] vid_addr,
  input  logic        vid_cs,
  output logic        vid_complete,
  output logic [7:0]  vid_data,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_di,
  input  logic        cpu_rw,
  input  logic        cpu_cs,
  output logic        cpu_ack,
  output logic [7:0]  cpu_do,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic        ram_ce,
  output logic        ram_we
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX = 8'(MAX_CPU_WAIT);

  state_t      state_q, state_d;
  logic        own_cpu_q, own_cpu_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic        vid_srv_q, vid_srv_d;
  logic        cpu_srv_q, cpu_srv_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic [7:0]  cpu_do_q, cpu_do_d;

  logic vid_req, cpu_req, starve;
  logic pulse_vid, pulse_cpu, act, cpu_wr;

  assign vid_req   = vid_cs & ~vid_srv_q;
  assign cpu_req   = cpu_cs & ~cpu_srv_q;
  assign starve    = cpu_req & (wait_q >= WAIT_MAX);
  assign pulse_vid = (state_q == DONE) & ~own_cpu_q;
  assign pulse_cpu = (state_q == DONE) & own_cpu_q;
  assign act       = (state_q == SETUP) | (state_q == ACCESS);
  assign cpu_wr    = own_cpu_q & ~rd_q;

  always_comb begin
    state_d    = state_q;
    own_cpu_d  = own_cpu_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    vid_data_d = vid_data_q;
    cpu_do_d   = cpu_do_q;
    // A low cs always clears served, even in the pulse cycle.
    vid_srv_d  = vid_cs & (vid_srv_q | pulse_vid);
    cpu_srv_d  = cpu_cs & (cpu_srv_q | pulse_cpu);
    unique case (state_q)
      IDLE: begin
        if (starve || (cpu_req && !vid_req)) begin
          own_cpu_d = 1'b1;
          addr_d    = cpu_addr;
          rd_d      = cpu_rw;
          wdata_d   = cpu_di;
          wait_d    = 8'd0;
          state_d   = SETUP;
        end else if (vid_req) begin
          own_cpu_d = 1'b0;
          addr_d    = vid_addr;
          rd_d      = 1'b1;
          wdata_d   = 8'd0;
          state_d   = SETUP;
          if (cpu_req && wait_q != 8'hff)
            wait_d = wait_q + 8'd1;
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (rd_q && own_cpu_q)
            cpu_do_d = ram_din;
          if (rd_q && !own_cpu_q)
            vid_data_d = ram_din;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
    if (!cpu_cs)
      wait_d = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      own_cpu_q  <= 1'b0;
      addr_q     <= 16'd0;
      rd_q       <= 1'b0;
      wdata_q    <= 8'd0;
      cnt_q      <= 4'd0;
      wait_q     <= 8'd0;
      vid_srv_q  <= 1'b0;
      cpu_srv_q  <= 1'b0;
      vid_data_q <= 8'd0;
      cpu_do_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      own_cpu_q  <= own_cpu_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      vid_srv_q  <= vid_srv_d;
      cpu_srv_q  <= cpu_srv_d;
      vid_data_q <= vid_data_d;
      cpu_do_q   <= cpu_do_d;
    end
  end

  assign ram_ce       = act;
  assign ram_we       = (state_q == ACCESS) & cpu_wr;
  assign ram_addr     = act ? addr_q : 16'd0;
  assign ram_dout     = (act & cpu_wr) ? wdata_q : 8'd0;
  assign vid_complete = pulse_vid;
  assign cpu_ack      = pulse_cpu;
  assign vid_data     = vid_data_q;
  assign cpu_do       = cpu_do_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a pulse scoreboard and a RAM model.
// Instance 0: ACCESS_CYCLES=2, MAX_CPU_WAIT=2; instance 1: ACCESS_CYCLES=1.
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] vid_addr0, cpu_addr0, ram_addr0;
  logic        vid_cs0, vid_complete0, cpu_rw0, cpu_cs0, cpu_ack0;
  logic [7:0]  vid_data0, cpu_di0, cpu_do0, ram_dout0, ram_din0;
  logic        ram_ce0, ram_we0;

  logic [15:0] vid_addr1, cpu_addr1, ram_addr1;
  logic        vid_cs1, vid_complete1, cpu_rw1, cpu_cs1, cpu_ack1;
  logic [7:0]  vid_data1, cpu_di1, cpu_do1, ram_dout1, ram_din1;
  logic        ram_ce1, ram_we1;

  logic [7:0] mem [0:65535];
  assign ram_din0 = mem[ram_addr0];
  assign ram_din1 = mem[ram_addr1];

  vram_arbiter #(.ACCESS_CYCLES(2), .MAX_CPU_WAIT(2)) dut0 (
    .clk(clk), .rst(rst),
    .vid_addr(vid_addr0), .vid_cs(vid_cs0),
    .vid_complete(vid_complete0), .vid_data(vid_data0),
    .cpu_addr(cpu_addr0), .cpu_di(cpu_di0), .cpu_rw(cpu_rw0),
    .cpu_cs(cpu_cs0), .cpu_ack(cpu_ack0), .cpu_do(cpu_do0),
    .ram_addr(ram_addr0), .ram_dout(ram_dout0), .ram_din(ram_din0),
    .ram_ce(ram_ce0), .ram_we(ram_we0)
  );

  vram_arbiter #(.ACCESS_CYCLES(1), .MAX_CPU_WAIT(8)) dut1 (
    .clk(clk), .rst(rst),
    .vid_addr(vid_addr1), .vid_cs(vid_cs1),
    .vid_complete(vid_complete1), .vid_data(vid_data1),
    .cpu_addr(cpu_addr1), .cpu_di(cpu_di1), .cpu_rw(cpu_rw1),
    .cpu_cs(cpu_cs1), .cpu_ack(cpu_ack1), .cpu_do(cpu_do1),
    .ram_addr(ram_addr1), .ram_dout(ram_dout1), .ram_din(ram_din1),
    .ram_ce(ram_ce1), .ram_we(ram_we1)
  );

  typedef struct {
    bit         cpu;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ce_cnt0 = 0;
  int we_cnt0 = 0;
  logic [15:0] ce_addr0 = '0;
  logic [7:0]  we_dout0 = '0;
  logic [7:0]  cpu_do_exp;
  int t;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pulse(input int id, input logic vc, input logic ca,
                             input logic [7:0] vd, input logic [7:0] cd);
    exp_t e;
    int sz;
    if (!(vc || ca)) return;
    sz = (id == 0) ? q0.size() : q1.size();
    chk($sformatf("sb%0d_pulse_expected", id), 32'(sz != 0), 32'd1);
    chk($sformatf("sb%0d_single_pulse", id), 32'(vc & ca), 32'd0);
    if (sz == 0) return;
    if (id == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk($sformatf("sb%0d_owner", id), 32'(ca), 32'(e.cpu));
    chk($sformatf("sb%0d_cycle", id), cyc, e.cyc);
    chk($sformatf("sb%0d_data", id), 32'(e.cpu ? cd : vd), 32'(e.data));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (ram_ce0) begin
      ce_cnt0++;
      ce_addr0 = ram_addr0;
    end
    if (ram_we0) begin
      we_cnt0++;
      we_dout0 = ram_dout0;
      mem[ram_addr0] = ram_dout0;
    end
    check_pulse(0, vid_complete0, cpu_ack0, vid_data0, cpu_do0);
    check_pulse(1, vid_complete1, cpu_ack1, vid_data1, cpu_do1);
  endtask

  initial begin
    rst = 1'b1;
    vid_addr0 = '0; vid_cs0 = 1'b0;
    cpu_addr0 = '0; cpu_di0 = '0; cpu_rw0 = 1'b1; cpu_cs0 = 1'b0;
    vid_addr1 = '0; vid_cs1 = 1'b0;
    cpu_addr1 = '0; cpu_di1 = '0; cpu_rw1 = 1'b1; cpu_cs1 = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    cpu_do_exp = 8'h00;
    repeat (2) step();

    chk("rst_ram_ce", 32'(ram_ce0), 32'd0);
    chk("rst_ram_we", 32'(ram_we0), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr0), 32'd0);
    chk("rst_ram_dout", 32'(ram_dout0), 32'd0);
    chk("rst_vid_complete", 32'(vid_complete0), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack0), 32'd0);
    chk("rst_vid_data", 32'(vid_data0), 32'd0);
    chk("rst_cpu_do", 32'(cpu_do0), 32'd0);
    rst = 1'b0;
    step();

    // video read, cs held past complete
    mem[16'hC123] = 8'h5A;
    t = cyc;
    vid_addr0 = 16'hC123;
    vid_cs0 = 1'b1;
    q0.push_back('{1'b0, 8'h5A, t + 4});
    ce_cnt0 = 0;
    repeat (6) step();
    chk("vid_ce_cycles", 32'(ce_cnt0), 32'd3);
    chk("vid_ce_addr", 32'(ce_addr0), 32'hC123);
    chk("vid_data_hold", 32'(vid_data0), 32'h5A);
    vid_cs0 = 1'b0;
    step();

    // cpu write
    t = cyc;
    cpu_addr0 = 16'h0010;
    cpu_di0 = 8'hA5;
    cpu_rw0 = 1'b0;
    cpu_cs0 = 1'b1;
    q0.push_back('{1'b1, cpu_do_exp, t + 4});
    ce_cnt0 = 0;
    we_cnt0 = 0;
    repeat (6) step();
    chk("wr_we_cycles", 32'(we_cnt0), 32'd2);
    chk("wr_ce_cycles", 32'(ce_cnt0), 32'd3);
    chk("wr_dout", 32'(we_dout0), 32'hA5);
    chk("wr_mem", 32'(mem[16'h0010]), 32'hA5);
    chk("wr_cpu_do_kept", 32'(cpu_do0), 32'(cpu_do_exp));
    cpu_cs0 = 1'b0;
    cpu_rw0 = 1'b1;
    step();

    // simultaneous requests: video first
    mem[16'h2000] = 8'h11;
    mem[16'h3000] = 8'h22;
    t = cyc;
    vid_addr0 = 16'h2000;
    vid_cs0 = 1'b1;
    cpu_addr0 = 16'h3000;
    cpu_cs0 = 1'b1;
    q0.push_back('{1'b0, 8'h11, t + 4});
    q0.push_back('{1'b1, 8'h22, t + 9});
    cpu_do_exp = 8'h22;
    repeat (4) step();
    vid_cs0 = 1'b0;
    repeat (6) step();
    cpu_cs0 = 1'b0;
    step();
    chk("sim_vid_data_hold", 32'(vid_data0), 32'h11);

    // starvation guard trips on the third arbitration
    mem[16'h4000] = 8'h33;
    mem[16'h4001] = 8'h44;
    mem[16'h4002] = 8'h55;
    mem[16'h5000] = 8'h66;
    t = cyc;
    vid_addr0 = 16'h4000;
    vid_cs0 = 1'b1;
    cpu_addr0 = 16'h5000;
    cpu_cs0 = 1'b1;
    q0.push_back('{1'b0, 8'h33, t + 4});
    q0.push_back('{1'b0, 8'h44, t + 9});
    q0.push_back('{1'b1, 8'h66, t + 14});
    q0.push_back('{1'b0, 8'h55, t + 19});
    cpu_do_exp = 8'h66;
    repeat (4) step();
    vid_cs0 = 1'b0;
    step();
    vid_addr0 = 16'h4001;
    vid_cs0 = 1'b1;
    repeat (4) step();
    vid_cs0 = 1'b0;
    step();
    vid_addr0 = 16'h4002;
    vid_cs0 = 1'b1;
    repeat (4) step();
    cpu_cs0 = 1'b0;
    repeat (5) step();
    vid_cs0 = 1'b0;
    step();
    chk("stv_cpu_do", 32'(cpu_do0), 32'h66);

    // reset during the access phase of a cpu write
    t = cyc;
    cpu_addr0 = 16'h6000;
    cpu_di0 = 8'h77;
    cpu_rw0 = 1'b0;
    cpu_cs0 = 1'b1;
    repeat (2) step();
    chk("rst_mid_we_before", 32'(ram_we0), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_we", 32'(ram_we0), 32'd0);
    chk("rst_mid_ce", 32'(ram_ce0), 32'd0);
    chk("rst_mid_ack", 32'(cpu_ack0), 32'd0);
    chk("rst_mid_cpu_do", 32'(cpu_do0), 32'd0);
    chk("rst_mid_vid_data", 32'(vid_data0), 32'd0);
    cpu_do_exp = 8'h00;
    step();
    rst = 1'b0;
    q0.push_back('{1'b1, cpu_do_exp, t + 7});
    we_cnt0 = 0;
    repeat (6) step();
    chk("rst_resvc_we_cycles", 32'(we_cnt0), 32'd2);
    chk("rst_resvc_mem", 32'(mem[16'h6000]), 32'h77);
    cpu_cs0 = 1'b0;
    cpu_rw0 = 1'b1;
    step();

    // ACCESS_CYCLES=1 back-to-back video reads
    mem[16'h0000] = 8'h81;
    mem[16'h0001] = 8'h82;
    t = cyc;
    vid_addr1 = 16'h0000;
    vid_cs1 = 1'b1;
    q1.push_back('{1'b0, 8'h81, t + 3});
    q1.push_back('{1'b0, 8'h82, t + 7});
    repeat (3) step();
    vid_cs1 = 1'b0;
    step();
    vid_addr1 = 16'h0001;
    vid_cs1 = 1'b1;
    repeat (3) step();
    vid_cs1 = 1'b0;
    repeat (2) step();

    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
